game_flow_ctrl: RTL
===================

# game_flow_ctrl

Screen sequencer and status-register owner for the counter game. It takes the level key vector from the matrix-keypad scanner and turns it into one-cycle key events. It runs the START/HELP/CHOOSE/PLAY screen FSM and applies cursor moves and counter edits to the packed 10×4-bit status register. It also schedules the wrap alarms onto the single shared buzzer, one at a time.

## Interface
- NUM_OBJ, 10: maximum number of objects (nibbles in `status`).
- BEEP_CYCLES, 25_000_000: length of one alarm, in clk cycles.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  16  keypad levels, already synchronous to clk. Key map: [2] up, [6] down, [7] left, [5] right, [12] exit, [13] back, [14] next, [15] help.
- screen  out  2  current screen: 00 START, 01 HELP, 10 CHOOSE, 11 PLAY.
- active_cnt  out  4  number of objects in play, range 1..NUM_OBJ.
- sel_idx  out  4  cursor position, range 0..active_cnt-1.
- status  out  4*NUM_OBJ  packed BCD counters; nibble i is `status[4i+:4]`.
- beep  out  1  buzzer enable.
- beep_idx  out  4  index of the object whose alarm is sounding.

## Operation
- Key events: `ev = btn & ~btn_q`, where `btn_q` is `btn` registered every clk. A held key produces exactly one event.
- Priority for simultaneous events:
  - ev12 first, then ev15, ev14, ev13, then the moves ev2, ev6, ev7, ev5.
  - Only the highest-priority event that is valid in the current screen acts; all others are dropped.
- START:
  - ev15 -> HELP.
  - ev14 -> CHOOSE.
- HELP:
  - ev13 -> START.
  - ev14 -> CHOOSE.
- CHOOSE:
  - ev2: active_cnt+1, saturating at NUM_OBJ.
  - ev6: active_cnt-1, saturating at 1.
  - ev12 -> START.
  - ev14 -> PLAY. On this transition, nibbles 0..active_cnt-1 load 1, all other nibbles load 0, and sel_idx loads 0.
- PLAY:
  - ev5: sel_idx+1, wrapping to 0 at active_cnt.
  - ev7: sel_idx-1, wrapping from 0 to active_cnt-1.
  - ev2: nibble[sel_idx]+1. On 9 -> 0, pending[sel_idx] is set.
  - ev6: nibble[sel_idx]-1. On 0 -> 9, no alarm is raised.
  - ev12 -> START. This clears status, the pending vector and beep; active_cnt is kept.
- Nibbles at index ≥ active_cnt are never modified in PLAY.
- Alarm scheduler:
  - pending[NUM_OBJ-1:0] is a set-only vector, cleared only when an alarm is granted.
  - Arbitration is lowest-index-first.
  - When idle, the scheduler grants the lowest set bit: beep_idx loads that index, the bit is cleared, and beep goes high for BEEP_CYCLES cycles.
  - A wrap of an index that is already pending has no further effect.
  - A wrap of the index that is currently sounding re-sets its pending bit, so one more alarm is queued.
- Reset (async assert, synchronous release): screen=START, active_cnt=1, sel_idx=0, status=0, beep=0, beep_idx=0, pending=0, btn_q=0.
- If reset is asserted mid-beep, beep drops immediately.

## Timing
- All outputs are registered.
- Key response: if btn[k] is first sampled high at edge N, the screen/counter/cursor update is visible after edge N.
- Alarm start: a wrap at edge E sets pending at E. beep rises at E+1 if the scheduler is idle.
- Alarm length: beep stays high for exactly BEEP_CYCLES edges.
- Alarm spacing: after beep falls, the scheduler spends one idle cycle before the next grant. Back-to-back alarms are therefore separated by exactly 1 low cycle.
- Exit during a beep: beep is low after the edge that takes ev12.

## Test plan
- Reset, then a pulse on btn[15], then a pulse on btn[13] -> screen goes 00 -> 01 -> 00. Every output equals its reset value before the first pulse.
- From START, btn[14]; press btn[2] 12 times; press btn[6] once; btn[14] -> active_cnt saturates at 10, then reads 9. Status becomes 0x0111111111 and sel_idx=0.
- PLAY with active_cnt=3: btn[7] once -> sel_idx=2; btn[5] once -> sel_idx=0. A held btn[5] of 100 cycles moves the cursor by exactly 1.
- PLAY, sel_idx=0, BEEP_CYCLES=4: press btn[2] nine times -> nibble0 reads 0. beep is high for exactly 4 cycles starting one cycle after the wrap edge, with beep_idx=0. A btn[6] at 0 gives 9 with no beep.
- Wrap index 2, then wrap index 1 during that beep -> beeps occur for index 2, then index 1, separated by 1 low cycle.
- Same-cycle rising edges of btn[12] and btn[2] in PLAY -> screen=START, status=0, no beep. Asserting rst_n low mid-beep -> beep=0 immediately.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Screen sequencer and status-register owner for the counter game: turns keypad
// levels into edge events, runs the START/HELP/CHOOSE/PLAY FSM and the alarm scheduler.
module game_flow_ctrl #(
  parameter int NUM_OBJ     = 10,
  parameter int BEEP_CYCLES = 25_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          btn,
  output logic [1:0]           screen,
  output logic [3:0]           active_cnt,
  output logic [3:0]           sel_idx,
  output logic [4*NUM_OBJ-1:0] status,
  output logic                 beep,
  output logic [3:0]           beep_idx
);

  typedef enum logic [1:0] {
    S_START  = 2'b00,
    S_HELP   = 2'b01,
    S_CHOOSE = 2'b10,
    S_PLAY   = 2'b11
  } screen_t;

  // Key slots ordered by priority: bit 7 wins over bit 0.
  localparam int K_EXIT  = 7;
  localparam int K_HELP  = 6;
  localparam int K_NEXT  = 5;
  localparam int K_BACK  = 4;
  localparam int K_UP    = 3;
  localparam int K_DOWN  = 2;
  localparam int K_LEFT  = 1;
  localparam int K_RIGHT = 0;

  localparam logic [7:0] VALID_START  = 8'b0110_0000;
  localparam logic [7:0] VALID_HELP   = 8'b0011_0000;
  localparam logic [7:0] VALID_CHOOSE = 8'b1010_1100;
  localparam logic [7:0] VALID_PLAY   = 8'b1000_1111;

  localparam int         CW      = $clog2(BEEP_CYCLES + 1);
  localparam logic [3:0] MAX_OBJ = 4'(NUM_OBJ);

  screen_t                    state_q, state_d;
  logic [7:0]                 keys, key_q, ev, evm, act, valid;
  logic [3:0]                 active_q, active_d, sel_q, sel_d;
  logic [NUM_OBJ-1:0][3:0]    nib_q, nib_d;
  logic [NUM_OBJ-1:0]         pending_q, pending_d, wrap_set, grant_clr;
  logic                       beep_q, beep_d;
  logic [3:0]                 bidx_q, bidx_d, gidx;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       play_exit;
  logic                       unused_keys;

  assign keys = {btn[12], btn[15], btn[14], btn[13], btn[2], btn[6], btn[7], btn[5]};
  assign unused_keys = ^{btn[11:8], btn[4:3], btn[1:0]};

  assign screen     = state_q;
  assign active_cnt = active_q;
  assign sel_idx    = sel_q;
  assign status     = nib_q;
  assign beep       = beep_q;
  assign beep_idx   = bidx_q;

  // NOTE: the counter nibbles are ordinary flops visible on a port, so they take the async reset like every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      key_q     <= '0;
      active_q  <= 4'd1;
      sel_q     <= '0;
      nib_q     <= '0;
      pending_q <= '0;
      beep_q    <= 1'b0;
      bidx_q    <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values computed by the comb block.
      state_q   <= state_d;
      key_q     <= keys;
      active_q  <= active_d;
      sel_q     <= sel_d;
      nib_q     <= nib_d;
      pending_q <= pending_d;
      beep_q    <= beep_d;
      bidx_q    <= bidx_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d   = state_q;
    active_d  = active_q;
    sel_d     = sel_q;
    nib_d     = nib_q;
    beep_d    = beep_q;
    bidx_d    = bidx_q;
    cnt_d     = cnt_q;
    wrap_set  = '0;
    grant_clr = '0;
    gidx      = '0;
    play_exit = 1'b0;
    act       = '0;

    case (state_q)
      S_START:  valid = VALID_START;
      S_HELP:   valid = VALID_HELP;
      S_CHOOSE: valid = VALID_CHOOSE;
      default:  valid = VALID_PLAY;
    endcase

    ev  = keys & ~key_q;
    evm = ev & valid;
    for (int i = 0; i < 8; i++) begin
      if (evm[i]) act = 8'b1 << i;
    end

    case (state_q)
      S_START: begin
        if (act[K_HELP])      state_d = S_HELP;
        else if (act[K_NEXT]) state_d = S_CHOOSE;
      end
      S_HELP: begin
        if (act[K_BACK])      state_d = S_START;
        else if (act[K_NEXT]) state_d = S_CHOOSE;
      end
      S_CHOOSE: begin
        if (act[K_EXIT]) begin
          state_d = S_START;
        end else if (act[K_NEXT]) begin
          state_d = S_PLAY;
          sel_d   = '0;
          for (int i = 0; i < NUM_OBJ; i++) nib_d[i] = (4'(i) < active_q) ? 4'd1 : 4'd0;
        end else if (act[K_UP]) begin
          if (active_q != MAX_OBJ) active_d = active_q + 4'd1;
        end else if (act[K_DOWN]) begin
          if (active_q != 4'd1) active_d = active_q - 4'd1;
        end
      end
      default: begin
        if (act[K_EXIT]) begin
          state_d   = S_START;
          nib_d     = '0;
          play_exit = 1'b1;
        end else if (act[K_UP]) begin
          if (nib_q[sel_q] == 4'd9) begin
            nib_d[sel_q]    = 4'd0;
            wrap_set[sel_q] = 1'b1;
          end else begin
            nib_d[sel_q] = nib_q[sel_q] + 4'd1;
          end
        end else if (act[K_DOWN]) begin
          nib_d[sel_q] = (nib_q[sel_q] == 4'd0) ? 4'd9 : nib_q[sel_q] - 4'd1;
        end else if (act[K_LEFT]) begin
          sel_d = (sel_q == 4'd0) ? active_q - 4'd1 : sel_q - 4'd1;
        end else if (act[K_RIGHT]) begin
          sel_d = (sel_q == active_q - 4'd1) ? 4'd0 : sel_q + 4'd1;
        end
      end
    endcase

    // Scheduler: an idle cycle always separates the end of one alarm from the next grant.
    if (beep_q) begin
      if (cnt_q == '0) beep_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end else if (|pending_q) begin
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
        if (pending_q[i]) gidx = 4'(i);
      end
      grant_clr[gidx] = 1'b1;
      beep_d          = 1'b1;
      bidx_d          = gidx;
      cnt_d           = CW'(BEEP_CYCLES - 1);
    end

    pending_d = (pending_q & ~grant_clr) | wrap_set;

    if (play_exit) begin
      pending_d = '0;
      beep_d    = 1'b0;
      cnt_d     = '0;
    end
  end

endmodule
